// File: rtl/ddr2_arb_pkg.sv
// Shared types for the ddr2_mgr request arbiter: owner codes, FSM states, default widths.
package ddr2_arb_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_LEN_W  = 10;

  typedef enum logic [1:0] {
    OWN_DISP = 2'd0,
    OWN_FRAC = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_NULL  = 2'd3
  } state_t;

  // Bit 0 display, bit 1 fractal, bit 2 CPU; no owner gives no pulse.
  function automatic logic [2:0] owner_onehot(input owner_t o);
    logic [2:0] oh;
    oh = 3'b000;
    case (o)
      OWN_DISP: oh = 3'b001;
      OWN_FRAC: oh = 3'b010;
      OWN_CPU:  oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ddr2_req_arb_if.sv
// Command port between the arbiter (master) and ddr2_mgr (slave).
interface ddr2_req_arb_if
  import ddr2_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_len;
  logic              mem_grant;
  logic              mem_done;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_len,
    input  mem_grant, mem_done
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_len,
    output mem_grant, mem_done
  );

endinterface

// File: rtl/ddr2_arb_pick.sv
// Combinational winner select: display first unless its streak is spent, then
// CPU/fractal by round-robin pointer, with display as last resort.
module ddr2_arb_pick
  import ddr2_arb_pkg::*;
(
  input  logic   disp_req,
  input  logic   frac_req,
  input  logic   cpu_req,
  input  logic   streak_full,
  input  logic   rr_cpu,
  output owner_t win
);

  always_comb begin
    win = OWN_NONE;
    if (disp_req && !streak_full)
      win = OWN_DISP;
    else if (cpu_req && (rr_cpu || !frac_req))
      win = OWN_CPU;
    else if (frac_req)
      win = OWN_FRAC;
    else if (disp_req)
      win = OWN_DISP;
  end

endmodule

// File: rtl/ddr2_req_arb.sv
// Shares the ddr2_mgr command port among display, fractal and CPU requesters.
// Request seen in IDLE gives mem_req next cycle; every output is registered.
module ddr2_req_arb
  import ddr2_arb_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int LEN_W           = DEF_LEN_W,
  parameter int MAX_DISP_STREAK = 4,
  parameter int TIMEOUT_CYC     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [LEN_W-1:0]  disp_len,
  output logic              disp_gnt,
  output logic              disp_done,
  input  logic              frac_req,
  input  logic [ADDR_W-1:0] frac_addr,
  input  logic [LEN_W-1:0]  frac_len,
  output logic              frac_gnt,
  output logic              frac_done,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LEN_W-1:0]  cpu_len,
  output logic              cpu_gnt,
  output logic              cpu_done,
  ddr2_req_arb_if.master    mem,
  output logic [1:0]        owner,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int SW = $clog2(MAX_DISP_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nxt;
  owner_t            own, own_nxt, win;
  logic [SW-1:0]     streak, streak_nxt;
  logic              rr_cpu, rr_nxt;
  logic [TW-1:0]     tmo_cnt, tmo_nxt;
  logic              cmd_req, req_nxt;
  logic              cmd_wr, wr_nxt;
  logic [ADDR_W-1:0] cmd_addr, addr_nxt;
  logic [LEN_W-1:0]  cmd_len, len_nxt;
  logic [2:0]        gnt_q, gnt_nxt, done_q, done_nxt;
  logic              err_nxt;
  logic              streak_full, others, tmo_hit;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic              win_wr;

  assign streak_full = (streak >= SW'(MAX_DISP_STREAK));
  assign others      = frac_req | cpu_req;
  assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  ddr2_arb_pick u_pick (
    .disp_req    (disp_req),
    .frac_req    (frac_req),
    .cpu_req     (cpu_req),
    .streak_full (streak_full),
    .rr_cpu      (rr_cpu),
    .win         (win)
  );

  always_comb begin
    win_addr = disp_addr;
    win_len  = disp_len;
    win_wr   = 1'b0;
    case (win)
      OWN_FRAC: begin win_addr = frac_addr; win_len = frac_len; win_wr = 1'b1;   end
      OWN_CPU:  begin win_addr = cpu_addr;  win_len = cpu_len;  win_wr = cpu_wr; end
      default:  ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    own_nxt    = own;
    streak_nxt = streak;
    rr_nxt     = rr_cpu;
    tmo_nxt    = '0;
    req_nxt    = cmd_req;
    wr_nxt     = cmd_wr;
    addr_nxt   = cmd_addr;
    len_nxt    = cmd_len;
    gnt_nxt    = 3'b000;
    done_nxt   = 3'b000;
    err_nxt    = err_timeout & ~err_clr;
    case (state)
      ST_IDLE: begin
        if (win != OWN_NONE) begin
          own_nxt  = win;
          wr_nxt   = win_wr;
          addr_nxt = win_addr;
          len_nxt  = win_len;
          if (win == OWN_DISP) begin
            if (!others)
              streak_nxt = '0;
            else if (!streak_full)
              streak_nxt = streak + 1'b1;
          end else begin
            streak_nxt = '0;
            rr_nxt     = ~rr_cpu;
          end
          // Zero-length transfers complete locally without touching ddr2_mgr.
          if (win_len == '0) begin
            state_nxt = ST_NULL;
            gnt_nxt   = owner_onehot(win);
          end else begin
            state_nxt = ST_ISSUE;
            req_nxt   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        tmo_nxt = tmo_cnt + 1'b1;
        if (tmo_hit) begin
          req_nxt   = 1'b0;
          gnt_nxt   = owner_onehot(own);
          done_nxt  = owner_onehot(own);
          own_nxt   = OWN_NONE;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (mem.mem_grant) begin
          req_nxt   = 1'b0;
          gnt_nxt   = owner_onehot(own);
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        tmo_nxt = tmo_cnt + 1'b1;
        if (tmo_hit || mem.mem_done) begin
          done_nxt  = owner_onehot(own);
          own_nxt   = OWN_NONE;
          state_nxt = ST_IDLE;
          if (tmo_hit)
            err_nxt = 1'b1;
        end
      end
      default: begin
        done_nxt  = owner_onehot(own);
        own_nxt   = OWN_NONE;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      own         <= OWN_NONE;
      streak      <= '0;
      rr_cpu      <= 1'b1;
      tmo_cnt     <= '0;
      cmd_req     <= 1'b0;
      cmd_wr      <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      gnt_q       <= 3'b000;
      done_q      <= 3'b000;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      own         <= own_nxt;
      streak      <= streak_nxt;
      rr_cpu      <= rr_nxt;
      tmo_cnt     <= tmo_nxt;
      cmd_req     <= req_nxt;
      cmd_wr      <= wr_nxt;
      cmd_addr    <= addr_nxt;
      cmd_len     <= len_nxt;
      gnt_q       <= gnt_nxt;
      done_q      <= done_nxt;
      err_timeout <= err_nxt;
    end
  end

  assign mem.mem_req  = cmd_req;
  assign mem.mem_wr   = cmd_wr;
  assign mem.mem_addr = cmd_addr;
  assign mem.mem_len  = cmd_len;
  assign owner        = own;
  assign disp_gnt     = gnt_q[0];
  assign frac_gnt     = gnt_q[1];
  assign cpu_gnt      = gnt_q[2];
  assign disp_done    = done_q[0];
  assign frac_done    = done_q[1];
  assign cpu_done     = done_q[2];

endmodule

// File: tb/tb_ddr2_req_arb.sv
// Directed bench for ddr2_req_arb with a hand-driven ddr2_mgr command port.
module tb_ddr2_req_arb;

  localparam int AW = 25;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [LW-1:0] disp_len = '0;
  logic          disp_gnt, disp_done;
  logic          frac_req = 1'b0;
  logic [AW-1:0] frac_addr = 25'h0123456;
  logic [LW-1:0] frac_len = 10'd32;
  logic          frac_gnt, frac_done;
  logic          cpu_req = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = 25'h1ABCDEF;
  logic [LW-1:0] cpu_len = 10'd4;
  logic          cpu_gnt, cpu_done;
  logic [1:0]    owner;
  logic          err_timeout;
  logic          err_clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  ddr2_req_arb_if #(.ADDR_W(AW), .LEN_W(LW)) mem_if ();

  ddr2_req_arb #(
    .ADDR_W(AW), .LEN_W(LW), .MAX_DISP_STREAK(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len),
    .disp_gnt(disp_gnt), .disp_done(disp_done),
    .frac_req(frac_req), .frac_addr(frac_addr), .frac_len(frac_len),
    .frac_gnt(frac_gnt), .frac_done(frac_done),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_len(cpu_len),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .mem(mem_if),
    .owner(owner), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a command, grant it, then complete it done_dly cycles later.
  task automatic run_xfer(input int done_dly, output logic [1:0] who,
                          output logic wr, output logic [AW-1:0] addr);
    int n;
    n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("mem_req_seen", 32'(mem_if.mem_req), 32'd1);
    wr   = mem_if.mem_wr;
    addr = mem_if.mem_addr;
    mem_if.mem_grant = 1'b1;
    tick();
    mem_if.mem_grant = 1'b0;
    if (disp_gnt)      who = 2'd0;
    else if (frac_gnt) who = 2'd1;
    else if (cpu_gnt)  who = 2'd2;
    else               who = 2'd3;
    repeat (done_dly) tick();
    mem_if.mem_done = 1'b1;
    tick();
    mem_if.mem_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]    who;
    logic          wr;
    logic [AW-1:0] addr;
    logic [1:0]    exp_df [10];
    logic [1:0]    exp_cf_who [4];
    logic          exp_cf_wr [4];
    logic          cf_cpu_wr [4];
    logic [1:0]    exp_rs [5];
    int            n;

    exp_df     = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    exp_cf_who = '{2'd2, 2'd1, 2'd2, 2'd1};
    cf_cpu_wr  = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_cf_wr  = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_rs     = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

    mem_if.mem_grant = 1'b0;
    mem_if.mem_done  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_if.mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_mem_len", 32'(mem_if.mem_len), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_gnts", 32'({disp_gnt, frac_gnt, cpu_gnt}), 32'd0);
    chk("rst_dones", 32'({disp_done, frac_done, cpu_done}), 32'd0);

    // Display-only read: exact latency of command, grant and done.
    disp_addr = 25'h0001000;
    disp_len  = 10'd640;
    disp_req  = 1'b1;
    tick();
    chk("d1_mem_req", 32'(mem_if.mem_req), 32'd1);
    chk("d1_mem_wr", 32'(mem_if.mem_wr), 32'd0);
    chk("d1_mem_len", 32'(mem_if.mem_len), 32'd640);
    chk("d1_mem_addr", 32'(mem_if.mem_addr), 32'h0001000);
    chk("d1_owner", 32'(owner), 32'd0);
    chk("d1_gnt_early", 32'(disp_gnt), 32'd0);
    mem_if.mem_grant = 1'b1;
    tick();
    mem_if.mem_grant = 1'b0;
    chk("d1_gnt", 32'(disp_gnt), 32'd1);
    chk("d1_req_drop", 32'(mem_if.mem_req), 32'd0);
    disp_req = 1'b0;
    tick();
    chk("d1_gnt_pulse", 32'(disp_gnt), 32'd0);
    tick();
    mem_if.mem_done = 1'b1;
    tick();
    mem_if.mem_done = 1'b0;
    chk("d1_done", 32'(disp_done), 32'd1);
    chk("d1_owner_none", 32'(owner), 32'd3);
    tick();
    chk("d1_done_pulse", 32'(disp_done), 32'd0);
    chk("d1_no_req", 32'(mem_if.mem_req), 32'd0);

    // Display and fractal both requesting continuously.
    disp_req = 1'b1;
    frac_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_xfer(2, who, wr, addr);
      chk($sformatf("df_order%0d", i), 32'(who), 32'(exp_df[i]));
    end
    disp_req = 1'b0;
    frac_req = 1'b0;
    tick();
    tick();

    // CPU and fractal: round-robin starting with CPU.
    cpu_req  = 1'b1;
    frac_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_wr = cf_cpu_wr[i];
      run_xfer(1, who, wr, addr);
      chk($sformatf("cf_who%0d", i), 32'(who), 32'(exp_cf_who[i]));
      chk($sformatf("cf_wr%0d", i), 32'(wr), 32'(exp_cf_wr[i]));
      chk($sformatf("cf_addr%0d", i), 32'(addr),
          (exp_cf_who[i] == 2'd2) ? 32'h1ABCDEF : 32'h0123456);
    end
    cpu_req  = 1'b0;
    frac_req = 1'b0;
    tick();
    tick();

    // Zero-length CPU access completes without a memory command.
    cpu_len = 10'd0;
    cpu_req = 1'b1;
    tick();
    chk("z_gnt", 32'(cpu_gnt), 32'd1);
    chk("z_mem_req0", 32'(mem_if.mem_req), 32'd0);
    chk("z_owner", 32'(owner), 32'd2);
    cpu_req = 1'b0;
    tick();
    chk("z_done", 32'(cpu_done), 32'd1);
    chk("z_gnt_pulse", 32'(cpu_gnt), 32'd0);
    chk("z_mem_req1", 32'(mem_if.mem_req), 32'd0);
    chk("z_owner_none", 32'(owner), 32'd3);
    tick();
    chk("z_done_pulse", 32'(cpu_done), 32'd0);
    cpu_len = 10'd4;

    // Timeout: grant given, done withheld.
    frac_req = 1'b1;
    tick();
    chk("t_mem_req", 32'(mem_if.mem_req), 32'd1);
    mem_if.mem_grant = 1'b1;
    tick();
    mem_if.mem_grant = 1'b0;
    frac_req = 1'b0;
    chk("t_gnt", 32'(frac_gnt), 32'd1);
    repeat (14) tick();
    chk("t_err_early", 32'(err_timeout), 32'd0);
    chk("t_done_early", 32'(frac_done), 32'd0);
    tick();
    chk("t_err", 32'(err_timeout), 32'd1);
    chk("t_done", 32'(frac_done), 32'd1);
    chk("t_owner", 32'(owner), 32'd3);
    tick();
    chk("t_err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t_err_clr", 32'(err_timeout), 32'd0);

    // Reset in BUSY after a display streak of four.
    disp_req = 1'b1;
    frac_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_xfer(1, who, wr, addr);
      chk($sformatf("r_pre%0d", i), 32'(who), 32'd0);
    end
    n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("r_req4", 32'(mem_if.mem_req), 32'd1);
    mem_if.mem_grant = 1'b1;
    tick();
    mem_if.mem_grant = 1'b0;
    chk("r_gnt4", 32'(disp_gnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_owner", 32'(owner), 32'd3);
    chk("r_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("r_done", 32'(disp_done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      run_xfer(1, who, wr, addr);
      chk($sformatf("r_post%0d", i), 32'(who), 32'(exp_rs[i]));
    end
    disp_req = 1'b0;
    frac_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr2_req_arb.md
# ddr2_req_arb

Shares the single `ddr2_mgr` transfer port between three requesters: `frame_buf` display line fetches, fractal-unit result writes and CPU diagnostic accesses. Display reads have priority, bounded by an anti-starvation streak limit. CPU and fractal alternate round-robin. The block owns the command side (request, address, length, direction) and reports the current owner so the top level steers data and data-valid signals. It sits in the memory clock domain, between the requesters and `ddr2_mgr`.

## Interface
Parameters:
- `ADDR_W`, 25, DDR2 word address width
- `LEN_W`, 10, transfer length width in 32-bit words
- `MAX_DISP_STREAK`, 4, consecutive display grants allowed while another request waits
- `TIMEOUT_CYC`, 4096, cycles allowed from `mem_req` to `mem_done`

Ports:
- `clk` in 1: memory-domain clock. One clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `disp_req` in 1, `disp_addr` in ADDR_W, `disp_len` in LEN_W: display read request (always a read).
- `disp_gnt` out 1, `disp_done` out 1: one-cycle pulses.
- `frac_req` in 1, `frac_addr` in ADDR_W, `frac_len` in LEN_W: fractal write request (always a write).
- `frac_gnt` out 1, `frac_done` out 1: one-cycle pulses.
- `cpu_req` in 1, `cpu_wr` in 1, `cpu_addr` in ADDR_W, `cpu_len` in LEN_W: CPU request; `cpu_wr`=1 means write.
- `cpu_gnt` out 1, `cpu_done` out 1: one-cycle pulses.
- `mem_req` out 1, `mem_wr` out 1, `mem_addr` out ADDR_W, `mem_len` out LEN_W: command to `ddr2_mgr`.
- `mem_grant` in 1: `ddr2_mgr` accepted the command.
- `mem_done` in 1: pulse when the transfer is complete.
- `owner` out 2: 0 = display, 1 = fractal, 2 = CPU, 3 = none.
- `err_timeout` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err_timeout`.

## Operation
- FSM states: IDLE, ISSUE, BUSY, NULL.
- IDLE: if any `*_req` is high, pick a winner, latch its addr/len/dir and set `owner`. Go to ISSUE, or to NULL if the latched len = 0.
- Winner selection:
  - Display wins if `disp_req` is high and streak < MAX_DISP_STREAK.
  - Otherwise the non-display requester per the round-robin pointer, which toggles after each fractal or CPU grant. At reset it favours CPU.
  - Display wins if it is the only requester, regardless of streak.
- Streak counter:
  - Increments on a display grant while `frac_req` or `cpu_req` is high.
  - Clears on any non-display grant, or on a display grant with no other request pending.
  - Saturates at MAX_DISP_STREAK.
- ISSUE: `mem_req`=1 with the latched command. On `mem_grant`: pulse the owner's `*_gnt`, deassert `mem_req`, go to BUSY.
- BUSY: on `mem_done`, pulse the owner's `*_done`, set `owner`=3, go to IDLE.
- NULL: pulse the owner's `*_gnt`, then `*_done` the next cycle, then go to IDLE. No memory command is issued.
- A request latched in IDLE is committed. Deasserting `*_req` afterwards does not cancel it.
- Requesters hold `*_req` and their command fields until `*_gnt`. They must drop `*_req` by the cycle after `*_done`, or they are re-arbitrated.
- Timeout:
  - A counter starts on entry to ISSUE and clears in IDLE.
  - When it reaches TIMEOUT_CYC in ISSUE or BUSY: set `err_timeout`, deassert `mem_req`, pulse the owner's `*_done` (plus `*_gnt` if not yet given), go to IDLE.
  - `err_clr` and a timeout in the same cycle leave the flag set.
- `mem_done` outside BUSY is ignored.

## Timing
- Reset values: every `*_gnt`/`*_done` = 0, `mem_req` = 0, `mem_wr` = 0, `mem_addr` = 0, `mem_len` = 0, `owner` = 3, `err_timeout` = 0. State = IDLE, streak = 0, round-robin pointer = CPU.
- Latency, request to command: request seen in IDLE at cycle t gives `mem_req` = 1 at t+1.
- `mem_grant` at cycle g gives `*_gnt` = 1 and `mem_req` = 0 at g+1.
- `mem_done` at cycle d gives `*_done` = 1 at d+1. IDLE is re-entered at d+1, and the next `mem_req` is at d+2 at the earliest.
- `mem_grant` and `mem_done` high in the same ISSUE cycle: the grant is taken and the done is ignored; `ddr2_mgr` never does this.
- All outputs are registered.
- `rst` during any state returns to IDLE the next cycle with reset values. The transfer in flight is abandoned.

## Structure
- Package `ddr2_arb_pkg`:
  - owner encodings OWN_DISP/OWN_FRAC/OWN_CPU/OWN_NONE
  - FSM state encoding
  - default ADDR_W/LEN_W
- Sub-module `ddr2_arb_pick`: purely combinational winner selection. Inputs are the three requests, the streak-limit-reached flag and the round-robin pointer; output is the owner code.
- The top module holds the FSM, command registers, streak counter, round-robin pointer and timeout counter.

## Test plan
- Display only, addr 0x0001000, len 640: `mem_req` one cycle later with `mem_wr`=0, `mem_len`=640. Grant at g gives `disp_gnt` at g+1; done at d gives `disp_done` at d+1.
- Display and fractal requesting continuously, MAX_DISP_STREAK=4: grant order D,D,D,D,F,D,D,D,D,F.
- CPU and fractal requesting together, no display: alternate C,F,C,F starting with C. `mem_wr` follows `cpu_wr` on CPU grants and is 1 on fractal grants.
- CPU len 0: `cpu_gnt` then `cpu_done` on consecutive cycles, `mem_req` never asserted.
- `mem_grant` given, `mem_done` withheld, TIMEOUT_CYC=16: `err_timeout`=1 and owner done 16 cycles after ISSUE entry. `err_clr` then clears it.
- `rst` pulsed in BUSY: next cycle `owner`=3, `mem_req`=0, streak=0. A later request is served normally.
